// File: rtl/rtc_pkg.sv
// Shared defaults and constants for the RTC alarm core.
// Contents: parameter defaults, overflow flag index helper, alarm reset value.
package rtc_pkg;

    localparam int unsigned CNT_WIDTH_DEF  = 32;
    localparam int unsigned PSCR_WIDTH_DEF = 16;
    localparam int unsigned ALRM_NUM_DEF   = 4;

    // Alarms come out of reset parked at all-ones; sliced to CNT_WIDTH at use.
    localparam logic [63:0] ALRM_RST = '1;

    // The overflow flag sits just above the per-alarm flags.
    function automatic int unsigned ovf_idx(input int unsigned alrm_num);
        return alrm_num;
    endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Prescaler: emits a combinational tick every pscr_i+1 enabled cycles.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   en_i         : count enable (freezes the prescaler when low)
//   clr_i        : restart the prescaler from 0, suppresses the tick
//   pscr_i       : divide value
//   tick_o       : tick in this cycle (combinational)
module rtc_tick_gen #(
    parameter int unsigned PSCR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    output logic                  tick_o
);

    logic [PSCR_WIDTH-1:0] psc_q, psc_d;

    // Equality (not >=) so a lowered pscr_i lets psc_q run through wrap first.
    assign tick_o = en_i & ~clr_i & (psc_q == pscr_i);

    always_comb begin
        psc_d = psc_q;
        if (clr_i) begin
            psc_d = '0;
        end else if (en_i) begin
            psc_d = tick_o ? '0 : psc_q + PSCR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) psc_q <= '0;
        else       psc_q <= psc_d;
    end

endmodule

// File: rtl/rtc_alarm_core.sv
// RTC counter with prescaler, compare alarms, sticky flags and interrupt.
// Optional feature macro: RTC_ALRM_PERIODIC_EN (periodic auto-reload alarms).
// Ports:
//   clk_i, rst_i        : clock, async active-high reset
//   en_i, pscr_i        : count enable, prescale value (tick every pscr_i+1)
//   cnt_wr_i, cnt_dat_i : counter load
//   alrm_wr_i/idx/dat   : alarm (or period) register write
//   alrm_en_i           : per-channel compare enable
//   ie_i, flag_clr_i    : interrupt enables, W1C flag clears (top bit = overflow)
//   cnt_o, tick_o       : count, registered tick pulse
//   flag_o, irq_o       : sticky flags, registered interrupt
//   alrm_prd_sel_i, alrm_mode_i (periodic build only): period select, periodic mode
module rtc_alarm_core
    import rtc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int unsigned PSCR_WIDTH = PSCR_WIDTH_DEF,
    parameter int unsigned ALRM_NUM   = ALRM_NUM_DEF,
    localparam int unsigned IDX_W     = (ALRM_NUM > 1) ? $clog2(ALRM_NUM) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    input  logic                  cnt_wr_i,
    input  logic [CNT_WIDTH-1:0]  cnt_dat_i,
    input  logic                  alrm_wr_i,
    input  logic [IDX_W-1:0]      alrm_idx_i,
    input  logic [CNT_WIDTH-1:0]  alrm_dat_i,
    input  logic [ALRM_NUM-1:0]   alrm_en_i,
`ifdef RTC_ALRM_PERIODIC_EN
    input  logic                  alrm_prd_sel_i,
    input  logic [ALRM_NUM-1:0]   alrm_mode_i,
`endif
    input  logic [ALRM_NUM:0]     ie_i,
    input  logic [ALRM_NUM:0]     flag_clr_i,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic                  tick_o,
    output logic [ALRM_NUM:0]     flag_o,
    output logic                  irq_o
);

    localparam int unsigned OVF = ovf_idx(ALRM_NUM);

    logic                 hit, adv, wr_ok;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 tick_q, tick_d;
    logic [ALRM_NUM:0]    flag_q, flag_d, flag_set;
    logic                 irq_q, irq_d;
    logic [ALRM_NUM-1:0]  match;
    logic [CNT_WIDTH-1:0] alrm_q [ALRM_NUM];
    logic [CNT_WIDTH-1:0] alrm_d [ALRM_NUM];
`ifdef RTC_ALRM_PERIODIC_EN
    logic [CNT_WIDTH-1:0] prd_q [ALRM_NUM];
    logic [CNT_WIDTH-1:0] prd_d [ALRM_NUM];
`endif

    rtc_tick_gen #(
        .PSCR_WIDTH (PSCR_WIDTH)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .clr_i  (cnt_wr_i),
        .pscr_i (pscr_i),
        .tick_o (hit)
    );

    always_comb begin
        // A load wins over a same-cycle tick and never sets flags.
        adv     = hit & ~cnt_wr_i;
        cnt_inc = cnt_q + CNT_WIDTH'(1);
        cnt_d   = cnt_q;
        if (cnt_wr_i)  cnt_d = cnt_dat_i;
        else if (adv)  cnt_d = cnt_inc;
        tick_d = adv;

        // Compare against the pre-write alarm so a same-cycle write cannot hide a match.
        flag_set      = '0;
        flag_set[OVF] = adv & (&cnt_q);
        for (int k = 0; k < ALRM_NUM; k++) begin
            match[k]    = adv & alrm_en_i[k] & (cnt_inc == alrm_q[k]);
            flag_set[k] = match[k];
        end
        flag_d = (flag_q & ~flag_clr_i) | flag_set;
        irq_d  = |(flag_q & ie_i);

        alrm_d = alrm_q;
        wr_ok  = alrm_wr_i & (32'(alrm_idx_i) < ALRM_NUM);
`ifdef RTC_ALRM_PERIODIC_EN
        prd_d = prd_q;
        for (int k = 0; k < ALRM_NUM; k++) begin
            if (match[k] && alrm_mode_i[k] && (prd_q[k] != '0)) begin
                alrm_d[k] = alrm_q[k] + prd_q[k];
            end
        end
        // Explicit writes override the auto-reload.
        if (wr_ok && alrm_prd_sel_i)       prd_d[alrm_idx_i]  = alrm_dat_i;
        else if (wr_ok)                    alrm_d[alrm_idx_i] = alrm_dat_i;
`else
        if (wr_ok) alrm_d[alrm_idx_i] = alrm_dat_i;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            flag_q <= '0;
            irq_q  <= 1'b0;
            for (int k = 0; k < ALRM_NUM; k++) begin
                alrm_q[k] <= ALRM_RST[CNT_WIDTH-1:0];
`ifdef RTC_ALRM_PERIODIC_EN
                prd_q[k]  <= '0;
`endif
            end
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            flag_q <= flag_d;
            irq_q  <= irq_d;
            alrm_q <= alrm_d;
`ifdef RTC_ALRM_PERIODIC_EN
            prd_q  <= prd_d;
`endif
        end
    end

    assign cnt_o  = cnt_q;
    assign tick_o = tick_q;
    assign flag_o = flag_q;
    assign irq_o  = irq_q;

endmodule
